// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku accelerator Wishbone arbiter: the
// ownership state encoding, master index constants and default watchdog limit.
package sudoku_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'b00,
      ARB_G0   = 2'b01,
      ARB_G1   = 2'b10
   } arbState_e;

   localparam logic MASTER0 = 1'b0;
   localparam logic MASTER1 = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/sudoku_arb_watchdog.sv
// Slave-stall watchdog: counts cycles of an unacknowledged strobe and raises a
// one-cycle timeout in the stall cycle that reaches TIMEOUT_CYCLES. Only
// instantiated by the arbiter when SUDOKU_ARB_TIMEOUT_EN is defined.
module sudoku_arb_watchdog
   import sudoku_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic stb_i,
   input  logic ack_i,
   input  logic grantChange_i,
   output logic timeout_o
);

   localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] LastStall = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] count_q;
   logic [CntW-1:0] count_d;

   // count_q holds the stall cycles already seen, so the current stall is the
   // TIMEOUT_CYCLES-th one when the counter sits one below the limit; an ack in
   // that same cycle takes priority and suppresses the timeout
   always_comb begin
      timeout_o = stb_i && !ack_i && (count_q == LastStall);
      count_d   = count_q;
      if (grantChange_i || !stb_i || ack_i || timeout_o) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // stall counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/sudoku_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the sudoku accelerator slave port.
// Grants are held for a whole cyc burst and ties are broken round-robin.
// Define SUDOKU_ARB_TIMEOUT_EN to build the slave-stall watchdog; without it
// the err outputs are tied low.
module sudoku_wb_arbiter
   import sudoku_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m0_dat_i,
   input  logic [31:0] m1_dat_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m0_we_i,
   input  logic        m1_we_i,
   input  logic        m0_cyc_i,
   input  logic        m1_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m1_stb_i,
   output logic        m0_ack_o,
   output logic        m1_ack_o,
   output logic        m0_err_o,
   output logic        m1_err_o,
   output logic [31:0] m0_dat_o,
   output logic [31:0] m1_dat_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o
);

   arbState_e state_q;
   arbState_e state_d;
   logic      last_q;
   logic      last_d;
   logic      stbRaw;
   logic      timeout;

   // Out-of-range limits elaborate this empty marker block so they stand out
   // in the elaborated hierarchy.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gTimeoutOutOfRange
   end

   // next owner: hold while the owner keeps cyc, hand over directly to a
   // waiting master when it drops, and on a tie from idle favour the master
   // that was not served last
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ARB_IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_d = (last_q == MASTER1) ? ARB_G0 : ARB_G1;
            end else if (m0_cyc_i) begin
               state_d = ARB_G0;
            end else if (m1_cyc_i) begin
               state_d = ARB_G1;
            end
         end
         ARB_G0: begin
            if (!m0_cyc_i) begin
               last_d  = MASTER0;
               state_d = m1_cyc_i ? ARB_G1 : ARB_IDLE;
            end
         end
         ARB_G1: begin
            if (!m1_cyc_i) begin
               last_d  = MASTER1;
               state_d = m0_cyc_i ? ARB_G0 : ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // ownership and round-robin pointer; m1 counts as last served out of reset
   // so m0 wins the first tie
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ARB_IDLE;
         last_q  <= MASTER1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

`ifdef SUDOKU_ARB_TIMEOUT_EN
   sudoku_arb_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) uWatchdog (
      .clk_i         (wb_clk_i),
      .rst_i         (wb_rst_i),
      .stb_i         (stbRaw),
      .ack_i         (s_ack_i),
      .grantChange_i (state_d != state_q),
      .timeout_o     (timeout)
   );
`else
   assign timeout = 1'b0;
`endif

   // request mux to the slave and response demux back to the owner only;
   // everything is zero while idle, and a timeout masks the strobe and turns
   // into an err pulse for the owner
   always_comb begin
      grant_o  = {state_q == ARB_G1, state_q == ARB_G0};
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      stbRaw   = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      case (state_q)
         ARB_G0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            stbRaw   = m0_stb_i;
            m0_ack_o = s_ack_i;
            m0_err_o = timeout;
            m0_dat_o = s_dat_i;
         end
         ARB_G1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            stbRaw   = m1_stb_i;
            m1_ack_o = s_ack_i;
            m1_err_o = timeout;
            m1_dat_o = s_dat_i;
         end
         default: begin
         end
      endcase
      s_stb_o = stbRaw && !timeout;
   end

endmodule

// File: tb/tb_sudoku_wb_arbiter.sv
// Self-checking bench for sudoku_wb_arbiter: a hand-computed grant table, a
// few directed sequences (single master, read routing, timeout, mid-burst
// reset) and a randomized run against a behavioural ownership model.
module tb_sudoku_wb_arbiter;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [31:0] m0_adr_i = '0, m1_adr_i = '0, m0_dat_i = '0, m1_dat_i = '0;
   logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
   logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
   logic        m0_cyc_i = 1'b0, m1_cyc_i = 1'b0, m0_stb_i = 1'b0, m1_stb_i = 1'b0;
   logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o, s_cyc_o, s_stb_o;
   logic        s_ack_i = 1'b0;
   logic [31:0] s_dat_i = '0;
   logic [1:0]  grant_o;

   int checkCount = 0;
   int errorCount = 0;

   // owner: -1 idle, 0 = m0, 1 = m1; lastOwner: master most recently released
   int modelOwner = -1;
   int modelLast  = 1;

   typedef struct {
      logic       c0;
      logic       c1;
      logic [1:0] expGrant;
   } grantVec_t;

   sudoku_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_adr_i(m0_adr_i), .m1_adr_i(m1_adr_i),
      .m0_dat_i(m0_dat_i), .m1_dat_i(m1_dat_i),
      .m0_sel_i(m0_sel_i), .m1_sel_i(m1_sel_i),
      .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
      .m0_cyc_i(m0_cyc_i), .m1_cyc_i(m1_cyc_i),
      .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
      .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
      .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
      .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // burst-level ownership rules, evaluated with the inputs seen at an edge
   task automatic modelAdvance();
      logic ownCyc, otherCyc;
      if (modelOwner < 0) begin
         if (m0_cyc_i && m1_cyc_i) modelOwner = 1 - modelLast;
         else if (m0_cyc_i)        modelOwner = 0;
         else if (m1_cyc_i)        modelOwner = 1;
      end else begin
         ownCyc   = (modelOwner == 0) ? m0_cyc_i : m1_cyc_i;
         otherCyc = (modelOwner == 0) ? m1_cyc_i : m0_cyc_i;
         if (!ownCyc) begin
            modelLast  = modelOwner;
            modelOwner = otherCyc ? 1 - modelOwner : -1;
         end
      end
   endtask

   task automatic tickClock();
      @(posedge wb_clk_i);
      modelAdvance();
      #1;
   endtask

   task automatic applyStimulus(input logic c0, input logic s0, input logic w0, input logic [31:0] a0,
                                input logic c1, input logic s1, input logic w1, input logic [31:0] a1,
                                input logic ack, input logic [31:0] sd);
      m0_cyc_i = c0; m0_stb_i = s0; m0_we_i = w0; m0_adr_i = a0;
      m1_cyc_i = c1; m1_stb_i = s1; m1_we_i = w1; m1_adr_i = a1;
      m0_dat_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      s_ack_i  = ack; s_dat_i = sd;
   endtask

   function automatic logic modelStb();
      if (modelOwner == 0) return m0_stb_i;
      if (modelOwner == 1) return m1_stb_i;
      return 1'b0;
   endfunction

   task automatic checkOutput(input string tag);
      logic [1:0]  eg;
      logic [72:0] eSlave;
      logic [33:0] eM0, eM1;
      eg = 2'b00; eSlave = '0; eM0 = '0; eM1 = '0;
      if (modelOwner == 0) begin
         eg     = 2'b01;
         eSlave = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i};
         eM0    = {s_ack_i, 1'b0, s_dat_i};
      end else if (modelOwner == 1) begin
         eg     = 2'b10;
         eSlave = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i};
         eM1    = {s_ack_i, 1'b0, s_dat_i};
      end
      checkVal({tag, " grant"}, 128'(grant_o), 128'(eg));
      checkVal({tag, " slave"}, 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o}), 128'(eSlave));
      checkVal({tag, " m0resp"}, 128'({m0_ack_o, m0_err_o, m0_dat_o}), 128'(eM0));
      checkVal({tag, " m1resp"}, 128'({m1_ack_o, m1_err_o, m1_dat_o}), 128'(eM1));
   endtask

   initial begin
      grantVec_t vecs[14];
      int stallRun;
      logic expErr, expStb;

      vecs[0]  = '{1'b1, 1'b1, 2'b00};
      vecs[1]  = '{1'b1, 1'b1, 2'b01};
      vecs[2]  = '{1'b0, 1'b1, 2'b01};
      vecs[3]  = '{1'b0, 1'b1, 2'b10};
      vecs[4]  = '{1'b1, 1'b1, 2'b10};
      vecs[5]  = '{1'b1, 1'b0, 2'b10};
      vecs[6]  = '{1'b1, 1'b1, 2'b01};
      vecs[7]  = '{1'b0, 1'b1, 2'b01};
      vecs[8]  = '{1'b0, 1'b1, 2'b10};
      vecs[9]  = '{1'b0, 1'b0, 2'b10};
      vecs[10] = '{1'b0, 1'b0, 2'b00};
      vecs[11] = '{1'b1, 1'b1, 2'b00};
      vecs[12] = '{1'b0, 1'b0, 2'b01};
      vecs[13] = '{1'b0, 1'b0, 2'b00};

      // reset state
      #2;
      checkOutput("reset");
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;

      // tie after reset, handover without idle, round-robin m0,m1,m0,m1
      for (int i = 0; i < 14; i++) begin
         tickClock();
         applyStimulus(vecs[i].c0, vecs[i].c0, 1'b1, 32'h3000_0100,
                       vecs[i].c1, vecs[i].c1, 1'b0, 32'h3080_0200, 1'b1, $urandom);
         #1;
         checkVal($sformatf("table[%0d] grant", i), 128'(grant_o), 128'(vecs[i].expGrant));
         checkOutput("table");
      end

      // single master write
      tickClock();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h3000_0010, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      m0_dat_i = 32'h0000_0005;
      #1;
      checkVal("single latency s_cyc", 128'(s_cyc_o), 128'(0));
      tickClock();
      s_ack_i = 1'b1;
      #1;
      checkVal("single s_cyc", 128'(s_cyc_o), 128'(1));
      checkVal("single s_adr", 128'(s_adr_o), 128'(32'h3000_0010));
      checkVal("single s_dat", 128'(s_dat_o), 128'(32'h0000_0005));
      checkVal("single grant", 128'(grant_o), 128'(2'b01));
      checkVal("single ack hi", 128'(m0_ack_o), 128'(1));
      s_ack_i = 1'b0;
      #1;
      checkVal("single ack lo", 128'(m0_ack_o), 128'(0));
      tickClock();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      tickClock();

      // read routing to m1
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h3080_0004, 1'b1, 32'hDEAD_BEEF);
      tickClock();
      #1;
      checkVal("read m1_dat", 128'(m1_dat_o), 128'(32'hDEAD_BEEF));
      checkVal("read m1_ack", 128'(m1_ack_o), 128'(1));
      checkVal("read m0_dat", 128'(m0_dat_o), 128'(0));
      checkVal("read m0_ack", 128'(m0_ack_o), 128'(0));
      checkVal("read s_adr", 128'(s_adr_o), 128'(32'h3080_0004));
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      tickClock();
      tickClock();

      // slave never acks m0: err on the 8th stall cycle only with the watchdog
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0020, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      for (int k = 1; k <= 10; k++) begin
         tickClock();
`ifdef SUDOKU_ARB_TIMEOUT_EN
         expErr = (k == 8);
`else
         expErr = 1'b0;
`endif
         expStb = !expErr;
         checkVal($sformatf("timeout err k=%0d", k), 128'(m0_err_o), 128'(expErr));
         checkVal($sformatf("timeout stb k=%0d", k), 128'(s_stb_o), 128'(expStb));
         checkVal($sformatf("timeout m1_err k=%0d", k), 128'(m1_err_o), 128'(0));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      tickClock();
      tickClock();

      // randomized bursts against the ownership model; stalls kept short
      stallRun = 0;
      for (int n = 0; n < 400; n++) begin
         logic c0, c1, ack;
         tickClock();
         c0  = m0_cyc_i ? ($urandom_range(99, 0) < 80) : ($urandom_range(99, 0) < 30);
         c1  = m1_cyc_i ? ($urandom_range(99, 0) < 80) : ($urandom_range(99, 0) < 30);
         ack = (stallRun >= 3) ? 1'b1 : 1'($urandom);
         applyStimulus(c0, c0 && ($urandom_range(3, 0) != 0), 1'($urandom), $urandom,
                       c1, c1 && ($urandom_range(3, 0) != 0), 1'($urandom), $urandom,
                       ack, $urandom);
         #1;
         checkOutput("random");
         stallRun = (modelStb() && !ack) ? stallRun + 1 : 0;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
      tickClock();
      tickClock();

      // reset in the middle of a G1 read
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h3080_0008, 1'b1, 32'h1234_5678);
      tickClock();
      checkVal("midrst pre grant", 128'(grant_o), 128'(2'b10));
      #2;
      wb_rst_i = 1'b1;
      #1;
      checkVal("midrst grant", 128'(grant_o), 128'(0));
      checkVal("midrst slave", 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o}), 128'(0));
      checkVal("midrst m1resp", 128'({m1_ack_o, m1_err_o, m1_dat_o}), 128'(0));
      checkVal("midrst m0resp", 128'({m0_ack_o, m0_err_o, m0_dat_o}), 128'(0));
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      modelOwner = -1;
      modelLast  = 1;
      wb_rst_i   = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h3000_0030, 1'b1, 1'b1, 1'b0, 32'h3080_0030, 1'b0, '0);
      tickClock();
      checkVal("postrst tie grant", 128'(grant_o), 128'(2'b01));
      checkOutput("postrst");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
